apb_register_slave: RTL

APB_REGISTER_SLAVE -- requirements
Module: apb_register_slave

---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_reg_bank.sv | 63 ++++++
 rtl/apb_register_slave.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB slave definitions: FSM state encoding and address-alignment constants.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } apb_state_e;

  // Word registers are addressed on 4-byte boundaries.
  localparam int unsigned ADDR_ALIGN_BITS = 2;

  // Wide enough for the largest supported wait-state count (15).
  localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/apb_reg_bank.sv
// Word register bank behind the APB slave: read-only ID at index 0, read/write
// storage at 1..REG_COUNT-1, plus combinational address/access error decode.
module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           REG_COUNT  = 8,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = DATA_WIDTH'(32'hA5B0_0001)
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_write,
  input  logic                  i_we,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata_c,
  output logic                  o_err_c
);

  localparam int unsigned IDX_W = ADDR_WIDTH - ADDR_ALIGN_BITS;

  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] regs_q [1:REG_COUNT-1];

  assign idx = i_addr[ADDR_WIDTH-1:ADDR_ALIGN_BITS];

  // Misaligned, out of range, or an attempt to overwrite the ID register.
  assign o_err_c = (i_addr[ADDR_ALIGN_BITS-1:0] != '0) ||
                   (idx >= IDX_W'(REG_COUNT)) ||
                   (i_write && (idx == '0));

  // Read mux; erroneous accesses return zero.
  always_comb begin
    o_rdata_c = '0;
    if (!o_err_c) begin
      if (idx == '0) begin
        o_rdata_c = ID_VALUE;
      end
      for (int i = 1; i < int'(REG_COUNT); i++) begin
        if (idx == IDX_W'(i)) begin
          o_rdata_c = regs_q[i];
        end
      end
    end
  end

  // Storage; writes are dropped when the decode flags an error.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 1; i < int'(REG_COUNT); i++) begin
        regs_q[i] <= '0;
      end
    end else if (i_we && !o_err_c) begin
      for (int i = 1; i < int'(REG_COUNT); i++) begin
        if (idx == IDX_W'(i)) begin
          regs_q[i] <= i_wdata;
        end
      end
    end
  end

endmodule

// File: rtl/apb_register_slave.sv
// APB register slave: IDLE/ACCESS/COMPLETE transfer FSM with registered outputs.
// Wait-state counter is present only when APB_SLAVE_WAIT_EN is defined.
module apb_register_slave
  import apb_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           REG_COUNT   = 8,
  parameter int unsigned           WAIT_CYCLES = 2,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(32'hA5B0_0001)
) (
  input  logic                  i_pclk,
  input  logic                  i_prstn,
  input  logic [ADDR_WIDTH-1:0] i_paddr,
  input  logic                  i_pwrite,
  input  logic                  i_psel,
  input  logic                  i_penable,
  input  logic [DATA_WIDTH-1:0] i_pwdata,
  output logic [DATA_WIDTH-1:0] o_prdata,
  output logic                  o_pready,
  output logic                  o_pslverr
);

  if ((WAIT_CYCLES > 15) || (REG_COUNT < 2) || (REG_COUNT > 256)) begin : g_param_check
    $error("apb_register_slave: WAIT_CYCLES or REG_COUNT out of range");
  end

  apb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  pready_d, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_d;
  logic                  reg_we_c;
  logic                  bank_err_c;
  logic [DATA_WIDTH-1:0] bank_rdata_c;
  logic                  cnt_zero_c;

`ifdef APB_SLAVE_WAIT_EN
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_zero_c = (cnt_q == '0);
`else
  assign cnt_zero_c = 1'b1;
`endif

  apb_reg_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .REG_COUNT  (REG_COUNT),
    .ID_VALUE   (ID_VALUE)
  ) u_bank (
    .i_clk     (i_pclk),
    .i_rstn    (i_prstn),
    .i_addr    (addr_q),
    .i_write   (write_q),
    .i_we      (reg_we_c),
    .i_wdata   (wdata_q),
    .o_rdata_c (bank_rdata_c),
    .o_err_c   (bank_err_c)
  );

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = o_prdata;
    reg_we_c  = 1'b0;
`ifdef APB_SLAVE_WAIT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_psel && !i_penable) begin
          addr_d  = i_paddr;
          write_d = i_pwrite;
          wdata_d = i_pwdata;
`ifdef APB_SLAVE_WAIT_EN
          cnt_d   = WAIT_CNT_W'(WAIT_CYCLES);
`endif
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!i_psel) begin
          state_d = IDLE;
        end else if (i_penable) begin
          if (cnt_zero_c) begin
            pready_d  = 1'b1;
            pslverr_d = bank_err_c;
            reg_we_c  = write_q;
            if (!write_q) begin
              prdata_d = bank_rdata_c;
            end
            state_d = COMPLETE;
          end
`ifdef APB_SLAVE_WAIT_EN
          else begin
            cnt_d = cnt_q - WAIT_CNT_W'(1);
          end
`endif
        end
      end
      COMPLETE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, transfer latches and registered bus outputs.
  always_ff @(posedge i_pclk or negedge i_prstn) begin
    if (!i_prstn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      o_pready  <= 1'b0;
      o_pslverr <= 1'b0;
      o_prdata  <= '0;
`ifdef APB_SLAVE_WAIT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      o_pready  <= pready_d;
      o_pslverr <= pslverr_d;
      o_prdata  <= prdata_d;
`ifdef APB_SLAVE_WAIT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

endmodule
